// File: rtl/hilo_muldiv_ctrl.sv
// hilo_muldiv_ctrl: iterative 32-step multiply/divide sequencer producing {hi,lo} for EX
// Ports: clk/rst (async active-high); mul_req/div_req/signed_op/src_a/src_b launch an op from EX;
// pipe_stall holds a finished result; cancel aborts; stallreq freezes IF..EX while iterating;
// res_valid/hi_res/lo_res present the result; busy flags a non-idle sequencer.
module hilo_muldiv_ctrl #(
    parameter int          ITER    = 32,
    parameter logic [31:0] DIV0_LO = 32'hFFFF_FFFF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        mul_req,
    input  logic        div_req,
    input  logic        signed_op,
    input  logic [31:0] src_a,
    input  logic [31:0] src_b,
    input  logic        pipe_stall,
    input  logic        cancel,
    output logic        stallreq,
    output logic        res_valid,
    output logic [31:0] hi_res,
    output logic [31:0] lo_res,
    output logic        busy
);
    localparam int CW = $clog2(ITER);
    typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;
    state_t state, nxt;
    logic [CW-1:0] cnt;
    logic [63:0] acc, acc_n, fin;
    logic [31:0] op, a_mag, b_mag;
    logic [32:0] sum, cand, diff;
    logic neg_q, neg_r, start, last, iter;
    assign start = mul_req | div_req;
    assign iter  = (state == MUL) || (state == DIV);
    assign last  = cnt == CW'(ITER - 1);
    assign a_mag = (signed_op && src_a[31]) ? -src_a : src_a;
    assign b_mag = (signed_op && src_b[31]) ? -src_b : src_b;
    // mul: acc = {partial high, remaining multiplier bits}; div: acc = {remainder, dividend/quotient}
    always_comb begin
        sum   = {1'b0, acc[63:32]} + (acc[0] ? {1'b0, op} : 33'd0);
        cand  = acc[63:31];
        diff  = cand - {1'b0, op};
        acc_n = (state == MUL) ? {sum, acc[31:1]} :
                diff[32] ? {cand[31:0], acc[30:0], 1'b0} : {diff[31:0], acc[30:0], 1'b1};
        fin   = (state == MUL) ? (neg_q ? -acc_n : acc_n) :
                {neg_r ? -acc_n[63:32] : acc_n[63:32], neg_q ? -acc_n[31:0] : acc_n[31:0]};
    end
    always_ff @(posedge clk or posedge rst)
        if (rst) state <= IDLE;
        else     state <= nxt;
    always_comb
        nxt = cancel ? IDLE :
              (state == IDLE) ? (start ? (mul_req ? MUL : (src_b == 32'd0 ? DONE : DIV)) : IDLE) :
              iter ? (last ? DONE : state) :
              (pipe_stall ? DONE : IDLE);
    always_comb begin
        stallreq  = !cancel && (iter || (state == IDLE && start));
        res_valid = !cancel && (state == DONE);
        busy      = state != IDLE;
    end
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            cnt    <= '0;
            acc    <= '0;
            op     <= '0;
            neg_q  <= 1'b0;
            neg_r  <= 1'b0;
            hi_res <= '0;
            lo_res <= '0;
        end else if (!cancel) begin
            if (state == IDLE && start) begin
                cnt   <= '0;
                neg_q <= signed_op && (src_a[31] ^ src_b[31]);
                neg_r <= signed_op && src_a[31] && !mul_req;
                op    <= mul_req ? a_mag : b_mag;
                acc   <= {32'd0, mul_req ? b_mag : a_mag};
                // divide-by-zero bypasses iteration and reports the raw dividend as remainder
                if (!mul_req && src_b == 32'd0) begin
                    hi_res <= src_a;
                    lo_res <= DIV0_LO;
                end
            end else if (iter) begin
                cnt <= cnt + 1'b1;
                acc <= acc_n;
                if (last) {hi_res, lo_res} <= fin;
            end
        end
endmodule

// File: tb/tb_hilo_muldiv_ctrl.sv
// tb_hilo_muldiv_ctrl: directed-vector bench for the HI/LO multiply/divide sequencer
module tb_hilo_muldiv_ctrl;
    logic clk = 0, rst = 1, mul_req = 0, div_req = 0, signed_op = 0, pipe_stall = 0, cancel = 0;
    logic [31:0] src_a = 0, src_b = 0;
    logic stallreq, res_valid, busy;
    logic [31:0] hi_res, lo_res;
    int vectors = 0, miscompares = 0;
    int st, lat;

    hilo_muldiv_ctrl dut (
        .clk(clk), .rst(rst), .mul_req(mul_req), .div_req(div_req), .signed_op(signed_op),
        .src_a(src_a), .src_b(src_b), .pipe_stall(pipe_stall), .cancel(cancel),
        .stallreq(stallreq), .res_valid(res_valid), .hi_res(hi_res), .lo_res(lo_res), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Launch an op and hold the request until res_valid; counts stall cycles and edges to DONE.
    task automatic run_op(input logic m, input logic d, input logic s, input logic [31:0] a,
                          input logic [31:0] b, output int stalls, output int cyc);
        mul_req = m; div_req = d; signed_op = s; src_a = a; src_b = b;
        stalls = 0; cyc = 0;
        #1;
        while (!res_valid && cyc < 60) begin
            stalls += int'(stallreq);
            step();
            cyc++;
            src_a = 32'hDEAD_BEEF ^ 32'(cyc);
            src_b = 32'h1234_5678 + 32'(cyc);
        end
    endtask

    task automatic retire();
        mul_req = 0; div_req = 0; pipe_stall = 0;
        step();
    endtask

    task automatic test_reset();
        #2;
        vectors++; if (stallreq !== 1'b0) begin miscompares++; $display("FAIL reset_stallreq got %b want 0", stallreq); end
        vectors++; if (res_valid !== 1'b0) begin miscompares++; $display("FAIL reset_res_valid got %b want 0", res_valid); end
        vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy got %b want 0", busy); end
        vectors++; if ({hi_res, lo_res} !== 64'd0) begin miscompares++; $display("FAIL reset_hilo got %h want 0", {hi_res, lo_res}); end
        step();
        rst = 0;
        step();
    endtask

    task automatic test_mul();
        logic [31:0] a[3] = '{32'hFFFF_FFFF, 32'hFFFF_FFFA, 32'hFFFF_FFFB};
        logic [31:0] b[3] = '{32'hFFFF_FFFF, 32'd7, 32'd0};
        logic        s[3] = '{1'b0, 1'b1, 1'b1};
        logic [63:0] e[3] = '{64'hFFFF_FFFE_0000_0001, 64'hFFFF_FFFF_FFFF_FFD6, 64'd0};
        for (int i = 0; i < 3; i++) begin
            run_op(1'b1, 1'b0, s[i], a[i], b[i], st, lat);
            vectors++; if (st !== 33) begin miscompares++; $display("FAIL mul%0d_stall_cycles got %0d want 33", i, st); end
            vectors++; if (lat !== 33) begin miscompares++; $display("FAIL mul%0d_latency got %0d want 33", i, lat); end
            vectors++; if ({hi_res, lo_res} !== e[i]) begin miscompares++; $display("FAIL mul%0d_result got %h want %h", i, {hi_res, lo_res}, e[i]); end
            vectors++; if (stallreq !== 1'b0) begin miscompares++; $display("FAIL mul%0d_done_stallreq got %b want 0", i, stallreq); end
            retire();
            vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL mul%0d_idle got busy=%b want 0", i, busy); end
        end
    endtask

    task automatic test_div();
        logic [31:0] a[3] = '{32'hFFFF_FFF9, 32'd100, 32'h8000_0000};
        logic [31:0] b[3] = '{32'd2, 32'd7, 32'hFFFF_FFFF};
        logic        s[3] = '{1'b1, 1'b0, 1'b1};
        logic [63:0] e[3] = '{64'hFFFF_FFFF_FFFF_FFFD, {32'd2, 32'd14}, 64'h0000_0000_8000_0000};
        for (int i = 0; i < 3; i++) begin
            run_op(1'b0, 1'b1, s[i], a[i], b[i], st, lat);
            vectors++; if (lat !== 33) begin miscompares++; $display("FAIL div%0d_latency got %0d want 33", i, lat); end
            vectors++; if ({hi_res, lo_res} !== e[i]) begin miscompares++; $display("FAIL div%0d_result got %h want %h", i, {hi_res, lo_res}, e[i]); end
            retire();
        end
    endtask

    task automatic test_div0();
        run_op(1'b0, 1'b1, 1'b0, 32'd5, 32'd0, st, lat);
        vectors++; if (st !== 1) begin miscompares++; $display("FAIL div0_stall_cycles got %0d want 1", st); end
        vectors++; if (lat !== 1) begin miscompares++; $display("FAIL div0_latency got %0d want 1", lat); end
        vectors++; if ({hi_res, lo_res} !== {32'd5, 32'hFFFF_FFFF}) begin miscompares++; $display("FAIL div0_result got %h want 00000005ffffffff", {hi_res, lo_res}); end
        retire();
    endtask

    task automatic test_hold();
        run_op(1'b0, 1'b1, 1'b0, 32'd100, 32'd7, st, lat);
        for (int i = 0; i < 4; i++) begin
            pipe_stall = 1;
            #1;
            vectors++; if (res_valid !== 1'b1 || stallreq !== 1'b0) begin miscompares++; $display("FAIL hold%0d_flags got valid=%b stall=%b want 1/0", i, res_valid, stallreq); end
            vectors++; if ({hi_res, lo_res} !== {32'd2, 32'd14}) begin miscompares++; $display("FAIL hold%0d_result got %h want 000000020000000e", i, {hi_res, lo_res}); end
            if (i < 3) step();
        end
        retire();
        vectors++; if (busy !== 1'b0 || res_valid !== 1'b0) begin miscompares++; $display("FAIL hold_release got busy=%b valid=%b want 0/0", busy, res_valid); end
        step();
        vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL hold_no_restart got busy=%b want 0", busy); end
    endtask

    task automatic test_cancel();
        mul_req = 0; div_req = 1; signed_op = 0; src_a = 32'd1000; src_b = 32'd3;
        for (int i = 0; i < 10; i++) step();
        cancel = 1;
        #1;
        vectors++; if (stallreq !== 1'b0 || res_valid !== 1'b0) begin miscompares++; $display("FAIL cancel_now got stall=%b valid=%b want 0/0", stallreq, res_valid); end
        div_req = 0;
        step();
        cancel = 0;
        #1;
        vectors++; if (busy !== 1'b0 || stallreq !== 1'b0) begin miscompares++; $display("FAIL cancel_idle got busy=%b stall=%b want 0/0", busy, stallreq); end
        vectors++; if ({hi_res, lo_res} !== {32'd2, 32'd14}) begin miscompares++; $display("FAIL cancel_hold got %h want 000000020000000e", {hi_res, lo_res}); end
        for (int i = 0; i < 30; i++) step();
        vectors++; if ({hi_res, lo_res} !== {32'd2, 32'd14} || res_valid !== 1'b0) begin miscompares++; $display("FAIL cancel_late got %h valid=%b want 000000020000000e/0", {hi_res, lo_res}, res_valid); end
    endtask

    task automatic test_reset_mid();
        mul_req = 1; signed_op = 0; src_a = 32'd9; src_b = 32'd9;
        for (int i = 0; i < 5; i++) step();
        rst = 1; mul_req = 0;
        #1;
        vectors++; if ({stallreq, res_valid, busy} !== 3'b000) begin miscompares++; $display("FAIL rst_mid_flags got %b want 000", {stallreq, res_valid, busy}); end
        vectors++; if ({hi_res, lo_res} !== 64'd0) begin miscompares++; $display("FAIL rst_mid_hilo got %h want 0", {hi_res, lo_res}); end
        step();
        rst = 0;
        step();
        run_op(1'b1, 1'b0, 1'b0, 32'd3, 32'd4, st, lat);
        vectors++; if (lat !== 33) begin miscompares++; $display("FAIL rst_mul_latency got %0d want 33", lat); end
        vectors++; if ({hi_res, lo_res} !== 64'd12) begin miscompares++; $display("FAIL rst_mul_result got %h want 000000000000000c", {hi_res, lo_res}); end
        retire();
    endtask

    initial begin
        test_reset();
        test_mul();
        test_div();
        test_div0();
        test_hold();
        test_cancel();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
